// File: rtl/mio_bus_n.sv
// Memory-mapped I/O bus: tag-decoded slot select, per-access ready handshake, timeout error.
// Optional MIO_ERR_CAPTURE_EN adds err_clr / err_addr / err_cnt error capture registers.
module mio_bus_n #(
    parameter int                       NUM_SLOTS = 4,
    parameter int                       ADDR_W    = 32,
    parameter int                       DATA_W    = 32,
    parameter logic [4*NUM_SLOTS-1:0]   SLOT_TAGS = 16'hFEC0,
    parameter int                       TIMEOUT   = 15
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [DATA_W-1:0]           cpu_wdata,
    output logic [DATA_W-1:0]           cpu_rdata,
    output logic                        cpu_ready,
    output logic                        cpu_err,
    output logic [NUM_SLOTS-1:0]        s_sel,
    output logic                        s_we,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    input  logic [NUM_SLOTS*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLOTS-1:0]        s_ready,
`ifdef MIO_ERR_CAPTURE_EN
    input  logic                        err_clr,
    output logic [ADDR_W-1:0]           err_addr,
    output logic [7:0]                  err_cnt,
`endif
    output logic [1:0]                  dbg_state
);

    // Handshake: cpu_req is sampled only in IDLE; cpu_ready is a one-cycle pulse and
    // cpu_err/cpu_rdata are meaningful only while it is high. s_ready is honoured only
    // for the slot whose s_sel bit is set.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam int              TW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLIM = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer, timer_d;
    logic [NUM_SLOTS-1:0]   dec_sel, sel_d;
    logic                   hit, sel_ready, timeout_hit;
    logic [DATA_W-1:0]      sel_rdata, rdata_d, wdata_d;
    logic [ADDR_W-1:0]      addr_d;
    logic                   we_d, ready_d, err_d;

    assign dbg_state = state_q;

    // Walk downward so the lowest matching slot index is the one left standing.
    always_comb begin
        dec_sel = '0;
        hit     = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (cpu_addr[ADDR_W-1 -: 4] == SLOT_TAGS[4*i +: 4]) begin
                dec_sel    = '0;
                dec_sel[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[DATA_W*i +: DATA_W];
        end
    end

    assign sel_ready   = |(s_ready & s_sel);
    assign timeout_hit = (TIMEOUT != 0) && (timer == TLIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            timer     <= '0;
            s_sel     <= '0;
            s_we      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer     <= timer_d;
            s_sel     <= sel_d;
            s_we      <= we_d;
            s_addr    <= addr_d;
            s_wdata   <= wdata_d;
            cpu_rdata <= rdata_d;
            cpu_ready <= ready_d;
            cpu_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cpu_req) state_d = hit ? ACCESS : RESP;
            ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d   = s_sel;
        we_d    = s_we;
        addr_d  = s_addr;
        wdata_d = s_wdata;
        rdata_d = cpu_rdata;
        timer_d = timer;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we & hit;
                    timer_d = '0;
                    if (hit) begin
                        sel_d = dec_sel;
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                timer_d = timer + 1'b1;
                if (sel_ready) begin
                    ready_d = 1'b1;
                    rdata_d = s_we ? '0 : sel_rdata;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end else if (timeout_hit) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                end
            end
            default: begin
                sel_d = '0;
                we_d  = 1'b0;
            end
        endcase
    end

`ifdef MIO_ERR_CAPTURE_EN
    logic              err_evt;
    logic [ADDR_W-1:0] err_at;

    // An unmapped access errors in IDLE, before the latched copy exists.
    assign err_evt = ready_d & err_d;
    assign err_at  = (state_q == IDLE) ? cpu_addr : s_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (err_clr) begin
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (err_evt) begin
            err_addr <= err_at;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
